multiport_register_file: RTL and testbench

Parametrised successor to the single-write, two-read register file for the MIPS core. Adds configurable read and write port counts, a hardwired zero register, write-to-read bypass and an asynchronous active-low reset that clears all state. Also holds a per-register busy scoreboard, so the issue stage can detect a read of a value still in flight from a multi-cycle or load producer. Sits between decode (reads, reservations) and writeback (ALU and load writes).

---
 rtl/mips_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 60 ++++++
 rtl/multiport_register_file.sv | 94 +++++++++
 tb/tb_multiport_register_file.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared defaults and slice helpers for the MIPS register file and its scoreboard.
// No logic and no state. The package only supplies constants and index arithmetic.
package mips_pkg;

  localparam int DATA_BITS_DEFAULT = 32;
  localparam int ADDR_BITS_DEFAULT = 5;
  localparam int REG_ZERO          = 0;

  // Low bit of element idx in a flat vector built from width-bit elements.
  function automatic int slice_base(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: a reservation sets a bit and an effective write clears it.
// Set/clear take effect at the next edge and lookup is combinational; there is no handshake.
module regfile_scoreboard
  import mips_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEFAULT,
  parameter int DEPTH     = 1 << ADDR_BITS,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 2,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_WRITE-1:0]          wr_eff_i,
  input  logic [NUM_WRITE*ADDR_BITS-1:0] waddr_i,
  input  logic [NUM_READ*ADDR_BITS-1:0]  raddr_i,
  input  logic                          reserve_en_i,
  input  logic [ADDR_BITS-1:0]          reserve_addr_i,
  output logic [NUM_READ-1:0]           rbusy_o
);

  logic [DEPTH-1:0] busy_q, busy_d;

  // A reserve in the same cycle as a write wins, because a newer producer now owns the register.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < DEPTH; r++) begin
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (wr_eff_i[j] && (waddr_i[slice_base(j, ADDR_BITS) +: ADDR_BITS] == ADDR_BITS'(r)))
          busy_d[r] = 1'b0;
      end
      if (reserve_en_i && (reserve_addr_i == ADDR_BITS'(r)) && !((ZERO_REG != 0) && (r == REG_ZERO)))
        busy_d[r] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  always_comb begin
    rbusy_o = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      for (int r = 0; r < DEPTH; r++) begin
        if (raddr_i[slice_base(k, ADDR_BITS) +: ADDR_BITS] == ADDR_BITS'(r))
          rbusy_o[k] = busy_q[r];
      end
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WRITE; j++) begin
          if (wr_eff_i[j] && (waddr_i[slice_base(j, ADDR_BITS) +: ADDR_BITS] ==
                              raddr_i[slice_base(k, ADDR_BITS) +: ADDR_BITS]))
            rbusy_o[k] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/multiport_register_file.sv
// Multiport register file with a zero register, write-to-read bypass and a busy scoreboard.
// Reads take 0 cycles and writes/reserves take 1 edge; inputs are always accepted with no backpressure.
module multiport_register_file
  import mips_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEFAULT,
  parameter int ADDR_BITS = ADDR_BITS_DEFAULT,
  parameter int DEPTH     = 1 << ADDR_BITS,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 2,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_READ*ADDR_BITS-1:0]  RAddress,
  output logic [NUM_READ*DATA_BITS-1:0]  RData,
  output logic [NUM_READ-1:0]            RBusy,
  input  logic [NUM_WRITE-1:0]           WriteEnable,
  input  logic [NUM_WRITE*ADDR_BITS-1:0] WAddress,
  input  logic [NUM_WRITE*DATA_BITS-1:0] WData,
  input  logic                           ReserveEnable,
  input  logic [ADDR_BITS-1:0]           ReserveAddress
);

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [DATA_BITS-1:0] mem_d [DEPTH];
  logic [ADDR_BITS-1:0] raddr [NUM_READ];
  logic [ADDR_BITS-1:0] waddr [NUM_WRITE];
  logic [DATA_BITS-1:0] wdata [NUM_WRITE];
  logic [NUM_WRITE-1:0] wr_eff;

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    assign raddr[k] = RAddress[slice_base(k, ADDR_BITS) +: ADDR_BITS];
  end
  for (genvar j = 0; j < NUM_WRITE; j++) begin : g_wr
    assign waddr[j] = WAddress[slice_base(j, ADDR_BITS) +: ADDR_BITS];
    assign wdata[j] = WData[slice_base(j, DATA_BITS) +: DATA_BITS];
  end

  always_comb begin
    wr_eff = '0;
    for (int j = 0; j < NUM_WRITE; j++)
      wr_eff[j] = WriteEnable[j] && (32'(waddr[j]) < 32'(DEPTH)) &&
                  !((ZERO_REG != 0) && (32'(waddr[j]) == 32'(REG_ZERO)));
  end

  // Ports are scanned in ascending order, so the highest-index port wins an address conflict.
  always_comb begin
    mem_d = mem_q;
    for (int r = 0; r < DEPTH; r++)
      for (int j = 0; j < NUM_WRITE; j++)
        if (wr_eff[j] && (waddr[j] == ADDR_BITS'(r))) mem_d[r] = wdata[j];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end

  // Bypass data is gated off during reset so that reads stay 0 even while writes are presented.
  always_comb begin
    RData = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      for (int r = 0; r < DEPTH; r++)
        if (raddr[k] == ADDR_BITS'(r)) RData[slice_base(k, DATA_BITS) +: DATA_BITS] = mem_q[r];
      if (BYPASS != 0)
        for (int j = 0; j < NUM_WRITE; j++)
          if (wr_eff[j] && (waddr[j] == raddr[k]))
            RData[slice_base(k, DATA_BITS) +: DATA_BITS] = wdata[j];
      if (((ZERO_REG != 0) && (raddr[k] == ADDR_BITS'(REG_ZERO))) || !rst_n)
        RData[slice_base(k, DATA_BITS) +: DATA_BITS] = '0;
    end
  end

  regfile_scoreboard #(
    .ADDR_BITS(ADDR_BITS),
    .DEPTH    (DEPTH),
    .NUM_READ (NUM_READ),
    .NUM_WRITE(NUM_WRITE),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_eff_i      (wr_eff),
    .waddr_i       (WAddress),
    .raddr_i       (RAddress),
    .reserve_en_i  (ReserveEnable),
    .reserve_addr_i(ReserveAddress),
    .rbusy_o       (RBusy)
  );

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench: a bypassing and a non-bypassing instance share one stimulus stream (DEPTH=24, 4 reads, 2 writes).
module tb_multiport_register_file;

  localparam int DB = 32;
  localparam int AB = 5;
  localparam int DP = 24;
  localparam int NR = 4;
  localparam int NW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NR*AB-1:0] raddr;
  logic [NR*DB-1:0] rdata_b, rdata_n;
  logic [NR-1:0]    rbusy_b, rbusy_n;
  logic [NW-1:0]    we;
  logic [NW*AB-1:0] waddr;
  logic [NW*DB-1:0] wdata;
  logic             res_en;
  logic [AB-1:0]    res_addr;
  int n_pass  = 0;
  int n_total = 0;

  multiport_register_file #(.DATA_BITS(DB), .ADDR_BITS(AB), .DEPTH(DP), .NUM_READ(NR),
                            .NUM_WRITE(NW), .ZERO_REG(1), .BYPASS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .RAddress(raddr), .RData(rdata_b), .RBusy(rbusy_b),
    .WriteEnable(we), .WAddress(waddr), .WData(wdata),
    .ReserveEnable(res_en), .ReserveAddress(res_addr));

  multiport_register_file #(.DATA_BITS(DB), .ADDR_BITS(AB), .DEPTH(DP), .NUM_READ(NR),
                            .NUM_WRITE(NW), .ZERO_REG(1), .BYPASS(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .RAddress(raddr), .RData(rdata_n), .RBusy(rbusy_n),
    .WriteEnable(we), .WAddress(waddr), .WData(wdata),
    .ReserveEnable(res_en), .ReserveAddress(res_addr));

  always #5 clk = ~clk;

  function automatic logic [DB-1:0] rd_b(input int k);
    return rdata_b[k*DB +: DB];
  endfunction
  function automatic logic [DB-1:0] rd_n(input int k);
    return rdata_n[k*DB +: DB];
  endfunction

  task automatic idle();
    we = '0; waddr = '0; wdata = '0; res_en = 1'b0; res_addr = '0;
  endtask
  task automatic set_rd(input int k, input int a);
    raddr[k*AB +: AB] = AB'(a);
  endtask
  task automatic set_wr(input int j, input int a, input logic [DB-1:0] d);
    we[j] = 1'b1; waddr[j*AB +: AB] = AB'(a); wdata[j*DB +: DB] = d;
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic settle();
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); raddr = '0; set_rd(0, 5);
    settle();
    n_total++;
    if (rd_b(0) !== 32'h0) $display("FAIL reset_rdata actual=%h required=%h", rd_b(0), 32'h0);
    else n_pass++;
    n_total++;
    if (rbusy_b !== 4'h0) $display("FAIL reset_rbusy actual=%h required=%h", rbusy_b, 4'h0);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    set_wr(0, 5, 32'hDEADBEEF); res_en = 1'b1; res_addr = 5'd6;
    tick();
    idle(); set_rd(1, 6);
    settle();
    n_total++;
    if (rd_n(0) !== 32'hDEADBEEF) $display("FAIL reset_prewrite actual=%h required=%h", rd_n(0), 32'hDEADBEEF);
    else n_pass++;
    n_total++;
    if (rbusy_n[1] !== 1'b1) $display("FAIL reset_prebusy actual=%b required=1", rbusy_n[1]);
    else n_pass++;
    // mid-cycle reset with a write still presented
    set_wr(0, 5, 32'h77); rst_n = 1'b0;
    #1;
    n_total++;
    if (rd_b(0) !== 32'h0 || rd_n(0) !== 32'h0)
      $display("FAIL reset_async_rdata actual=%h/%h required=0", rd_b(0), rd_n(0));
    else n_pass++;
    n_total++;
    if (rbusy_b !== 4'h0 || rbusy_n !== 4'h0)
      $display("FAIL reset_async_rbusy actual=%h/%h required=0", rbusy_b, rbusy_n);
    else n_pass++;
    idle(); #1; rst_n = 1'b1;
    tick(); settle();
    n_total++;
    if (rd_n(0) !== 32'h0) $display("FAIL reset_after actual=%h required=0", rd_n(0));
    else n_pass++;
  endtask

  task automatic test_zero();
    tick(); idle();
    set_wr(0, 0, 32'h12345678); set_rd(0, 0);
    settle();
    n_total++;
    if (rd_b(0) !== 32'h0 || rd_n(0) !== 32'h0)
      $display("FAIL zero_same_cycle actual=%h/%h required=0", rd_b(0), rd_n(0));
    else n_pass++;
    tick(); idle(); res_en = 1'b1; res_addr = 5'd0;
    settle();
    n_total++;
    if (rd_b(0) !== 32'h0) $display("FAIL zero_after actual=%h required=0", rd_b(0));
    else n_pass++;
    tick(); idle(); settle();
    n_total++;
    if (rbusy_b[0] !== 1'b0) $display("FAIL zero_busy actual=%b required=0", rbusy_b[0]);
    else n_pass++;
  endtask

  task automatic test_conflict();
    tick(); idle();
    set_wr(0, 7, 32'h1111); set_wr(1, 7, 32'h2222); set_rd(1, 7);
    settle();
    n_total++;
    if (rd_b(1) !== 32'h2222) $display("FAIL conflict_bypass actual=%h required=%h", rd_b(1), 32'h2222);
    else n_pass++;
    n_total++;
    if (rd_n(1) !== 32'h0) $display("FAIL conflict_nobypass_old actual=%h required=0", rd_n(1));
    else n_pass++;
    tick(); idle(); settle();
    n_total++;
    if (rd_n(1) !== 32'h2222) $display("FAIL conflict_commit actual=%h required=%h", rd_n(1), 32'h2222);
    else n_pass++;
    tick(); set_wr(0, 3, 32'hA); set_wr(1, 4, 32'hB);
    tick(); idle(); set_rd(0, 3); set_rd(1, 4);
    settle();
    n_total++;
    if (rd_n(0) !== 32'hA || rd_n(1) !== 32'hB)
      $display("FAIL dual_write actual=%h/%h required=a/b", rd_n(0), rd_n(1));
    else n_pass++;
  endtask

  task automatic test_bypass();
    tick(); idle(); set_wr(0, 9, 32'h1234);
    tick(); idle(); set_wr(1, 9, 32'hCAFE); set_rd(2, 9);
    settle();
    n_total++;
    if (rd_b(2) !== 32'hCAFE) $display("FAIL bypass_on actual=%h required=%h", rd_b(2), 32'hCAFE);
    else n_pass++;
    n_total++;
    if (rd_n(2) !== 32'h1234) $display("FAIL bypass_off_old actual=%h required=%h", rd_n(2), 32'h1234);
    else n_pass++;
    tick(); idle(); settle();
    n_total++;
    if (rd_n(2) !== 32'hCAFE) $display("FAIL bypass_off_late actual=%h required=%h", rd_n(2), 32'hCAFE);
    else n_pass++;
  endtask

  task automatic test_scoreboard();
    tick(); idle(); res_en = 1'b1; res_addr = 5'd12; set_rd(2, 12);
    settle();
    n_total++;
    if (rbusy_b[2] !== 1'b0) $display("FAIL sb_cycle0 actual=%b required=0", rbusy_b[2]);
    else n_pass++;
    tick(); idle(); settle();
    n_total++;
    if (rbusy_b[2] !== 1'b1 || rbusy_n[2] !== 1'b1)
      $display("FAIL sb_cycle1 actual=%b/%b required=1/1", rbusy_b[2], rbusy_n[2]);
    else n_pass++;
    tick(); tick();
    set_wr(0, 12, 32'h5);
    settle();
    n_total++;
    if (rbusy_b[2] !== 1'b0 || rbusy_n[2] !== 1'b1)
      $display("FAIL sb_write_cycle actual=%b/%b required=0/1", rbusy_b[2], rbusy_n[2]);
    else n_pass++;
    tick(); idle(); settle();
    n_total++;
    if (rbusy_b[2] !== 1'b0 || rbusy_n[2] !== 1'b0)
      $display("FAIL sb_cleared actual=%b/%b required=0/0", rbusy_b[2], rbusy_n[2]);
    else n_pass++;
    tick(); res_en = 1'b1; res_addr = 5'd12; set_wr(1, 12, 32'h6);
    tick(); idle(); settle();
    n_total++;
    if (rbusy_b[2] !== 1'b1 || rd_b(2) !== 32'h6)
      $display("FAIL sb_set_priority actual=%b,%h required=1,6", rbusy_b[2], rd_b(2));
    else n_pass++;
  endtask

  task automatic test_depth();
    tick(); idle();
    set_wr(1, 28, 32'h5555); set_wr(0, 23, 32'h2323); set_rd(3, 28);
    settle();
    n_total++;
    if (rd_b(3) !== 32'h0) $display("FAIL depth_no_bypass actual=%h required=0", rd_b(3));
    else n_pass++;
    tick(); idle(); res_en = 1'b1; res_addr = 5'd28; set_rd(0, 23);
    settle();
    n_total++;
    if (rd_n(3) !== 32'h0 || rd_n(0) !== 32'h2323)
      $display("FAIL depth_rw actual=%h/%h required=0/2323", rd_n(3), rd_n(0));
    else n_pass++;
    tick(); idle(); settle();
    n_total++;
    if (rbusy_b[3] !== 1'b0) $display("FAIL depth_busy actual=%b required=0", rbusy_b[3]);
    else n_pass++;
  endtask

  task automatic test_four_reads();
    tick(); idle();
    set_rd(0, 3); set_rd(1, 4); set_rd(2, 7); set_rd(3, 9);
    settle();
    n_total++;
    if (rd_b(0) !== 32'hA || rd_b(1) !== 32'hB || rd_b(2) !== 32'h2222 || rd_b(3) !== 32'hCAFE)
      $display("FAIL four_reads actual=%h/%h/%h/%h required=a/b/2222/cafe",
               rd_b(0), rd_b(1), rd_b(2), rd_b(3));
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    tick(); idle(); set_wr(0, 10, 32'h1); set_rd(0, 10);
    tick(); set_wr(0, 10, 32'h2);
    settle();
    n_total++;
    if (rd_n(0) !== 32'h1 || rd_b(0) !== 32'h2)
      $display("FAIL b2b_mid actual=%h/%h required=1/2", rd_n(0), rd_b(0));
    else n_pass++;
    tick(); idle(); settle();
    n_total++;
    if (rd_n(0) !== 32'h2) $display("FAIL b2b_final actual=%h required=2", rd_n(0));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_conflict();
    test_bypass();
    test_scoreboard();
    test_depth();
    test_four_reads();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
